// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame reader: 640x480@60 timing,
// frame size, pixel format encodings and colour-bar palette.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 8;

    localparam int FRAME_PIXELS_DEFAULT = H_VISIBLE * V_VISIBLE;

    localparam int PIX_FMT_GRAY   = 0;
    localparam int PIX_FMT_RGB332 = 1;

    localparam int BAR_WIDTH = 80;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BAR_WHITE   = 24'hFF_FF_FF;
    localparam rgb_t BAR_YELLOW  = 24'hFF_FF_00;
    localparam rgb_t BAR_CYAN    = 24'h00_FF_FF;
    localparam rgb_t BAR_GREEN   = 24'h00_FF_00;
    localparam rgb_t BAR_MAGENTA = 24'hFF_00_FF;
    localparam rgb_t BAR_RED     = 24'hFF_00_00;
    localparam rgb_t BAR_BLUE    = 24'h00_00_FF;
    localparam rgb_t BAR_BLACK   = 24'h00_00_00;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// BRAM read port plus VGA DAC signals of the frame reader, bundled as one bus.
interface vga_frame_reader_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  pixel_data;
    logic              vga_clk;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_blank_n;
    logic              vga_sync_n;
    logic [7:0]        vga_r;
    logic [7:0]        vga_g;
    logic [7:0]        vga_b;

    modport master (
        output rd_addr, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        output vga_r, vga_g, vga_b,
        input  pixel_data
    );

    modport slave (
        input  rd_addr, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        input  vga_r, vga_g, vga_b,
        output pixel_data
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel-enable phase, raster counters and raw (undelayed) sync/visible flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             visible,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SW);

    logic             phase;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 1'b0;
        else        phase <= ~phase;
    end

    assign pix_tick = phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign hs_raw      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign visible     = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);
    assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the frame buffer in raster order and drives the VGA DAC, with a
// colour-bar fallback selected once per frame.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int PIX_FMT      = PIX_FMT_GRAY,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int V_VIS        = V_VISIBLE,
    parameter int V_FP         = V_FRONT,
    parameter int V_SW         = V_SYNC,
    parameter int V_BP         = V_BACK
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       test_pattern,
    output logic                       frame_start,
    vga_frame_reader_if.master         bus
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

    logic             pix_tick;
    logic [CNT_W-1:0] h_cnt;
    logic             hs_raw;
    logic             vs_raw;
    logic             visible;
    logic             frame_last;

    logic [ADDR_W-1:0] addr;

    logic       hs_p0;
    logic       vs_p0;
    logic       vld_p0;
    logic       tp_p0;
    logic [2:0] bar_p0;
    logic       tp_frame;
    rgb_t       rgb_nxt;

    function automatic rgb_t pixel_to_rgb(input logic [PIX_W-1:0] px);
        rgb_t c;
        if (PIX_FMT == PIX_FMT_RGB332) begin
            c.r = {px[7:5], px[7:5], px[7:6]};
            c.g = {px[4:2], px[4:2], px[4:3]};
            c.b = {px[1:0], px[1:0], px[1:0], px[1:0]};
        end else begin
            c.r = px;
            c.g = px;
            c.b = px;
        end
        return c;
    endfunction

    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h);
        logic [2:0] idx;
        idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i * BAR_WIDTH)) idx = 3'(i);
        end
        return idx;
    endfunction

    vga_timing #(
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SW  (V_SW),
        .V_BP  (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .h_cnt       (h_cnt),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .visible     (visible),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    // Address tracks the pixel the counters will show next, so it is already
    // on rd_addr throughout that pixel's two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (pix_tick) begin
            if (frame_last)             addr <= '0;
            else if (visible)           addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
        end
    end

    assign bus.rd_addr = addr;

    // Stage p0: capture flags at the pixel tick; BRAM data arrives one tick later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p0    <= 1'b1;
            vs_p0    <= 1'b1;
            vld_p0   <= 1'b0;
            bar_p0   <= '0;
            tp_p0    <= 1'b0;
            tp_frame <= 1'b0;
        end else if (pix_tick) begin
            hs_p0  <= hs_raw;
            vs_p0  <= vs_raw;
            vld_p0 <= visible;
            bar_p0 <= bar_index(h_cnt);
            if (frame_start) begin
                tp_frame <= test_pattern;
                tp_p0    <= test_pattern;
            end else begin
                tp_p0    <= tp_frame;
            end
        end
    end

    always_comb begin
        rgb_nxt = '0;
        if (vld_p0) rgb_nxt = tp_p0 ? bar_colour(bar_p0) : pixel_to_rgb(bus.pixel_data);
    end

    // Output stage: every DAC signal updates together on the clock after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vga_clk     <= 1'b0;
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.vga_blank_n <= 1'b0;
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
        end else begin
            bus.vga_clk <= pix_tick;
            if (!pix_tick) begin
                bus.vga_hs      <= hs_p0;
                bus.vga_vs      <= vs_p0;
                bus.vga_blank_n <= vld_p0;
                bus.vga_r       <= rgb_nxt.r;
                bus.vga_g       <= rgb_nxt.g;
                bus.vga_b       <= rgb_nxt.b;
            end
        end
    end

    assign bus.vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: grayscale/test-pattern instance and an
// RGB332 instance with a small wrapping frame, both on a shortened vertical raster.
module tb_vga_frame_reader;
    import vga_pkg::*;

    localparam int TB_V_VIS = 4;
    localparam int TB_V_FP  = 1;
    localparam int TB_V_SW  = 2;
    localparam int TB_V_BP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tp0   = 1'b0;
    logic tp1   = 1'b0;
    logic fs0;
    logic fs1;
    logic [7:0] q0_d1;
    logic [7:0] q1_d1;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    vga_frame_reader_if bus0 ();
    vga_frame_reader_if bus1 ();

    always #10 clk = ~clk;

    // Two-clock BRAM model returning the low address byte.
    always @(posedge clk) begin
        q0_d1           <= bus0.rd_addr[7:0];
        bus0.pixel_data <= q0_d1;
        q1_d1           <= bus1.rd_addr[7:0];
        bus1.pixel_data <= q1_d1;
    end

    vga_frame_reader #(
        .PIX_FMT      (0),
        .FRAME_PIXELS (2560),
        .V_VIS        (TB_V_VIS),
        .V_FP         (TB_V_FP),
        .V_SW         (TB_V_SW),
        .V_BP         (TB_V_BP)
    ) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .test_pattern (tp0),
        .frame_start  (fs0),
        .bus          (bus0)
    );

    vga_frame_reader #(
        .PIX_FMT      (1),
        .FRAME_PIXELS (1000),
        .V_VIS        (TB_V_VIS),
        .V_FP         (TB_V_FP),
        .V_SW         (TB_V_SW),
        .V_BP         (TB_V_BP)
    ) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .test_pattern (tp1),
        .frame_start  (fs1),
        .bus          (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic goto(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    function automatic logic [31:0] rgb0();
        return {8'h00, bus0.vga_r, bus0.vga_g, bus0.vga_b};
    endfunction

    function automatic logic [31:0] rgb1();
        return {8'h00, bus1.vga_r, bus1.vga_g, bus1.vga_b};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_hs",      32'(bus0.vga_hs),      32'd1);
        check_eq("rst_vs",      32'(bus0.vga_vs),      32'd1);
        check_eq("rst_blank_n", 32'(bus0.vga_blank_n), 32'd0);
        check_eq("rst_rgb",     rgb0(),                32'h0);
        check_eq("rst_vga_clk", 32'(bus0.vga_clk),     32'd0);
        check_eq("rst_sync_n",  32'(bus0.vga_sync_n),  32'd0);
        check_eq("rst_fs",      32'(fs0),              32'd0);
        check_eq("rst_addr",    32'(bus0.rd_addr),     32'd0);
        check_eq("rst_rgb_332", rgb1(),                32'h0);

        rst_n = 1'b1;
        k = 0;
        goto(1);
        check_eq("fs_first",      32'(fs0),             32'd1);
        check_eq("addr_first",    32'(bus0.rd_addr),    32'd0);
        check_eq("vga_clk_k1",    32'(bus0.vga_clk),    32'd0);
        check_eq("blank_k1",      32'(bus0.vga_blank_n), 32'd0);
        goto(2);
        check_eq("fs_k2",         32'(fs0),             32'd0);
        check_eq("vga_clk_k2",    32'(bus0.vga_clk),    32'd1);
        check_eq("blank_k2",      32'(bus0.vga_blank_n), 32'd0);
        goto(3);
        check_eq("blank_k3",      32'(bus0.vga_blank_n), 32'd1);
        check_eq("addr_h1",       32'(bus0.rd_addr),    32'd1);
        goto(13);
        check_eq("gray_h5",       rgb0(),               32'h05_05_05);
        goto(59);
        check_eq("rgb332_1c",     rgb1(),               32'h00_FF_00);
        goto(457);
        check_eq("rgb332_e3",     rgb1(),               32'hFF_00_FF);
        goto(1000);
        tp0 = 1'b1;
        goto(1282);
        check_eq("blank_last_vis", 32'(bus0.vga_blank_n), 32'd1);
        goto(1283);
        check_eq("blank_h640",    32'(bus0.vga_blank_n), 32'd0);
        goto(1314);
        check_eq("hs_h655",       32'(bus0.vga_hs),     32'd1);
        goto(1315);
        check_eq("hs_h656",       32'(bus0.vga_hs),     32'd0);
        goto(1401);
        check_eq("addr_hold_blank", 32'(bus0.rd_addr),  32'd640);
        goto(1403);
        check_eq("rgb_blank",     rgb0(),               32'h0);
        check_eq("rgb332_blank",  rgb1(),               32'h0);
        goto(1506);
        check_eq("hs_h751",       32'(bus0.vga_hs),     32'd0);
        goto(1507);
        check_eq("hs_h752",       32'(bus0.vga_hs),     32'd1);
        goto(1601);
        check_eq("addr_line1",    32'(bus0.rd_addr),    32'd640);
        goto(1773);
        check_eq("tp_no_midframe", rgb0(),              32'hD5_D5_D5);
        goto(1803);
        check_eq("gray_line1_h100", rgb0(),             32'hE4_E4_E4);
        goto(2319);
        check_eq("addr_wrap_last", 32'(bus1.rd_addr),   32'd999);
        goto(2321);
        check_eq("addr_wrap_zero", 32'(bus1.rd_addr),   32'd0);
        goto(2915);
        check_eq("hs_period",     32'(bus0.vga_hs),     32'd0);
        goto(6079);
        check_eq("addr_last_vis", 32'(bus0.rd_addr),    32'd2559);
        goto(8002);
        check_eq("vs_before",     32'(bus0.vga_vs),     32'd1);
        goto(8003);
        check_eq("vs_start",      32'(bus0.vga_vs),     32'd0);
        goto(11202);
        check_eq("vs_end",        32'(bus0.vga_vs),     32'd0);
        goto(11203);
        check_eq("vs_after",      32'(bus0.vga_vs),     32'd1);
        goto(14401);
        check_eq("fs_frame1",     32'(fs0),             32'd1);
        check_eq("addr_frame1",   32'(bus0.rd_addr),    32'd0);
        goto(14402);
        check_eq("fs_frame1_end", 32'(fs0),             32'd0);
        goto(14403);
        check_eq("tp_white",      rgb0(),               32'hFF_FF_FF);
        goto(14573);
        check_eq("tp_yellow_h85", rgb0(),               32'hFF_FF_00);
        goto(15681);
        check_eq("tp_black_h639", rgb0(),               32'h00_00_00);
        check_eq("tp_black_blank", 32'(bus0.vga_blank_n), 32'd1);
        goto(16500);
        check_eq("tp_green_pre_rst", rgb0(),            32'h00_FF_00);

        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_hs",    32'(bus0.vga_hs),      32'd1);
        check_eq("mid_rst_blank", 32'(bus0.vga_blank_n), 32'd0);
        check_eq("mid_rst_rgb",   rgb0(),                32'h0);
        check_eq("mid_rst_addr",  32'(bus0.rd_addr),     32'd0);
        repeat (4) @(negedge clk);
        check_eq("mid_rst_vga_clk", 32'(bus0.vga_clk),   32'd0);
        check_eq("mid_rst_fs",    32'(fs0),              32'd0);

        tp0 = 1'b0;
        rst_n = 1'b1;
        k = 0;
        goto(1);
        check_eq("restart_fs",    32'(fs0),             32'd1);
        check_eq("restart_addr",  32'(bus0.rd_addr),    32'd0);
        goto(3);
        check_eq("restart_blank", 32'(bus0.vga_blank_n), 32'd1);
        goto(13);
        check_eq("restart_gray",  rgb0(),               32'h05_05_05);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
